// File: rtl/cache_write_buffer.sv
// cache_write_buffer: write-back buffer between the cache controller and main memory.
// Captures evicted dirty words one per cycle, drains them in order over a valid/ready
// handshake, merges writes to an address already buffered, and forwards buffered
// data to line-fill reads.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wr_en_i/wr_addr_i/wr_data_i  push from the cache controller
//   rd_addr_i -> rd_hit_o/rd_data_o  combinational forwarding lookup
//   mem_valid_o/mem_addr_o/mem_data_o/mem_ready_i  drain handshake toward memory
//   full_o, empty_o, count_o, overflow_o           status
module cache_write_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic                    rd_hit_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    mem_valid_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic                    mem_ready_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = ADDR_WIDTH - 2;

  logic [TW-1:0]         tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;

  logic [TW-1:0] wr_tag, rd_tag;
  logic          pop, alloc, drop, any_match;
  logic [PW-1:0] match_idx;
  logic          fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic          unused_low_bits;

  assign wr_tag = wr_addr_i[ADDR_WIDTH-1:2];
  assign rd_tag = rd_addr_i[ADDR_WIDTH-1:2];
  // Byte-offset bits never participate in matching.
  assign unused_low_bits = ^{wr_addr_i[1:0], rd_addr_i[1:0]};

  assign pop = (count_q != '0) && mem_ready_i;

  // Coalesce lookup over entries that survive this cycle (a popping head does not).
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_en_i && valid_q[i] && !(pop && (PW'(i) == head_q)) && (tag_q[i] == wr_tag)) begin
        any_match = 1'b1;
        match_idx = PW'(i);
      end
    end
  end

  assign alloc = wr_en_i && !any_match && ((count_q != CW'(DEPTH)) || pop);
  assign drop  = wr_en_i && !any_match && (count_q == CW'(DEPTH)) && !pop;

  // Forwarding: a same-cycle write wins over stored data; popping head still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (tag_q[i] == rd_tag)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[i];
      end
    end
    if (wr_en_i && (wr_tag == rd_tag)) begin
      fwd_hit  = 1'b1;
      fwd_data = wr_data_i;
    end
  end

  assign rd_hit_o  = fwd_hit;
  assign rd_data_o = fwd_data;

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      // Placed after the pop so a full-buffer alloc into the freed slot stays valid.
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage; contents are don't-care until marked valid.
  always_ff @(posedge clk_i) begin
    if (any_match) data_q[match_idx] <= wr_data_i;
    if (alloc) begin
      tag_q[tail_q]  <= wr_tag;
      data_q[tail_q] <= wr_data_i;
    end
  end

  assign mem_valid_o = (count_q != '0);
  assign mem_addr_o  = mem_valid_o ? {tag_q[head_q], 2'b00} : '0;
  assign mem_data_o  = mem_valid_o ? data_q[head_q] : '0;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Self-checking bench for cache_write_buffer: queue-based reference model,
// expected memory beats scoreboarded and compared by an independent monitor.
module tb_cache_write_buffer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic        rd_hit, mem_valid, mem_ready = 1'b0, full, empty, overflow;
  logic [31:0] rd_data, mem_addr, mem_data;
  logic [3:0]  count;

  cache_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_hit_o(rd_hit), .rd_data_o(rd_data),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_ready_i(mem_ready),
    .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of buffered words.
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  logic        m_ovf = 1'b0;
  // Scoreboard of beats memory must receive, in order.
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every completed handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got 0x%0h/0x%0h expected none", mem_addr, mem_data);
      end else begin
        chk("beat_addr", mem_addr, exp_a.pop_front());
        chk("beat_data", mem_data, exp_d.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, check against the model, then advance the model.
  task automatic cycle(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] ra);
    logic        pop, matched, f_hit;
    logic [31:0] f_data, wtag;
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd; mem_ready = rdy; rd_addr = ra;
    #1;
    wtag = wa & ~32'h3;
    chk("count", 32'(count), 32'(m_addr.size()));
    chk("full", 32'(full), 32'(m_addr.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_addr.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("mem_valid", 32'(mem_valid), 32'(m_addr.size() != 0));
    if (m_addr.size() != 0) begin
      chk("head_addr", mem_addr, m_addr[0]);
      chk("head_data", mem_data, m_data[0]);
    end
    f_hit = 1'b0;
    f_data = '0;
    if (we && wtag == (ra & ~32'h3)) begin
      f_hit = 1'b1; f_data = wd;
    end else begin
      foreach (m_addr[i]) if (m_addr[i] == (ra & ~32'h3)) begin
        f_hit = 1'b1; f_data = m_data[i];
      end
    end
    chk("rd_hit", 32'(rd_hit), 32'(f_hit));
    chk("rd_data", rd_data, f_data);
    // Advance the model across the coming edge.
    pop = (m_addr.size() != 0) && rdy;
    if (pop) begin
      exp_a.push_back(m_addr[0]);
      exp_d.push_back(m_data[0]);
    end
    matched = 1'b0;
    if (we) begin
      for (int i = (pop ? 1 : 0); i < m_addr.size(); i++)
        if (m_addr[i] == wtag) begin
          m_data[i] = wd; matched = 1'b1;
        end
    end
    if (pop) begin
      void'(m_addr.pop_front());
      void'(m_data.pop_front());
    end
    if (we && !matched) begin
      if (m_addr.size() < DEPTH) begin
        m_addr.push_back(wtag); m_data.push_back(wd);
      end else m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; wr_en = 1'b0; mem_ready = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_addr.delete(); m_data.delete(); m_ovf = 1'b0;
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_hit", 32'(rd_hit), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 32'h0);
  endtask

  initial begin
    do_reset();

    // Two pushes held, then drained in order.
    cycle(1'b1, 32'h100, 32'h11, 1'b0, 32'h0);
    cycle(1'b1, 32'h104, 32'h22, 1'b0, 32'h0);
    idle(1'b0, 1);
    idle(1'b1, 2);
    idle(1'b0, 1);

    // Fill, drop a 9th, coalesce into a full buffer.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 32'h40 + 32'(i), 1'b0, 32'h0);
    cycle(1'b1, 32'h180, 32'h77, 1'b0, 32'h0);
    cycle(1'b1, 32'h100, 32'h99, 1'b0, 32'h100);
    idle(1'b0, 1);

    // Push while full and popping; then wrap and drain with a stream of new words.
    cycle(1'b1, 32'h1C0, 32'h55, 1'b1, 32'h0);
    for (int i = 0; i < 20; i++) cycle(i < 10, 32'h400 + 32'(4 * i), 32'h500 + 32'(i), 1'b1, 32'h0);
    idle(1'b1, 2);

    // Forwarding.
    do_reset();
    cycle(1'b1, 32'h200, 32'hAB, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h200);
    cycle(1'b1, 32'h200, 32'hCD, 1'b0, 32'h200);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h204);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h200);

    // Write to a head that is popping allocates a new entry.
    do_reset();
    cycle(1'b1, 32'h300, 32'h1, 1'b0, 32'h0);
    cycle(1'b1, 32'h300, 32'h2, 1'b1, 32'h300);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // Reset mid-drain with five entries.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    do_reset();

    // Random traffic over a small address pool to exercise merge, full and drop.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, r;
      a = 32'h1000 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
      r = 32'h1000 + 32'(4 * $urandom_range(0, 12)) + 32'($urandom_range(0, 3));
      cycle(($urandom_range(0, 3) != 0), a, $urandom, ($urandom_range(0, 2) == 0), r);
      if (i == 300) do_reset();
    end
    idle(1'b1, 12);

    total++;
    if (exp_a.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending beats expected 0", exp_a.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Write-back buffer between the cache controller's memory port and main memory. It captures dirty words evicted during the controller's write-back phase at one word per cycle and drains them to a slower memory through a valid/ready handshake. It forwards buffered data to line-fill reads so a refill never returns stale memory contents. Writes to an address already held in the buffer are merged in place.

## Interface
- DEPTH, 8: number of word entries; power of two, ≥ 2
- ADDR_WIDTH, 32: byte address width; bits [1:0] are ignored for matching and always driven 0 toward memory
- DATA_WIDTH, 32: word width
- clk_i  in  1  clock; one clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous and active-high
- wr_en_i  in  1  push request from the cache controller (its mem_write_en)
- wr_addr_i  in  ADDR_WIDTH  word address of the evicted word
- wr_data_i  in  DATA_WIDTH  evicted word
- rd_addr_i  in  ADDR_WIDTH  line-fill read address from the cache controller
- rd_hit_o  out  1  rd_addr_i matches a live entry or a same-cycle write
- rd_data_o  out  DATA_WIDTH  forwarded word; 0 when rd_hit_o=0
- mem_valid_o  out  1  head entry offered to memory
- mem_addr_o  out  ADDR_WIDTH  head entry address, bits [1:0]=0
- mem_data_o  out  DATA_WIDTH  head entry data
- mem_ready_i  in  1  memory accepts the head this cycle
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- count_o  out  $clog2(DEPTH)+1  live entries
- overflow_o  out  1  sticky: a push was dropped; cleared only by reset

## Operation
- Circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register. Each entry holds address[ADDR_WIDTH-1:2] and data.
- Pop: when mem_valid_o && mem_ready_i, the head leaves and head advances by 1.
- Push with wr_en_i:
  - Coalesce: wr_addr_i[ADDR_WIDTH-1:2] is compared against every live entry that survives this cycle. An entry does not survive if it is the head and is being popped. On a match, that entry's data is overwritten, count is unchanged, and no new entry is allocated. At most one live entry per address exists, so a match is unique.
  - Allocate: with no match and (count < DEPTH or a pop occurs this cycle), the word is written at tail and tail advances.
  - Drop: with no match, count == DEPTH and no pop, the word is discarded and overflow_o sets. The controller must not rely on this; it holds its write-back while full_o=1.
- A write to the head address while the head is being popped allocates a new entry. The popped beat carries the old data and the new word drains later.
- Forwarding is combinational. Priority order:
  - same-cycle wr_en_i with a matching address gives wr_data_i;
  - otherwise a matching live entry gives its data, including a head being popped this cycle;
  - otherwise rd_hit_o=0 and rd_data_o=0.
- count_next = count + alloc − pop. Simultaneous alloc and pop leaves count unchanged and is legal when full.
- Reset mid-drain abandons all entries: pointers 0, count 0. Memory sees mem_valid_o drop with no completing handshake.

## Timing
- Reset values: mem_valid_o=0, mem_addr_o=0, mem_data_o=0, full_o=0, empty_o=1, count_o=0, overflow_o=0. With no write active, rd_hit_o=0 and rd_data_o=0.
- Push-to-offer latency: a word allocated into an empty buffer in cycle N appears on mem_valid_o/mem_addr_o/mem_data_o in cycle N+1. There is no same-cycle bypass to memory.
- mem_valid_o, mem_addr_o, mem_data_o, full_o, empty_o and count_o derive from registers only.
- While mem_valid_o=1 and mem_ready_i=0, mem_addr_o stays stable. mem_data_o stays stable too, except when a coalescing write to the head updates it in the next cycle.
- Throughput: one push and one pop per cycle, sustained.
- rd_hit_o and rd_data_o are combinational from rd_addr_i, wr_* and the stored state in the same cycle.

## Test plan
- Reset, then push A=0x100/D=0x11 and B=0x104/D=0x22 with mem_ready_i=0 → count_o=2, mem_valid_o=1, mem_addr_o=0x100. Raise ready for 2 cycles → beats 0x100/0x11 then 0x104/0x22, then empty_o=1.
- With DEPTH=8, ready=0: push 8 distinct addresses → full_o=1. Push a 9th new address → dropped, overflow_o=1, count_o=8. Push 0x100 with 0x99 → coalesced, count_o=8, overflow_o stays 1.
- Full buffer with ready=1 and a new push in the same cycle → accepted, count_o stays 8. Tail wraps and drain order matches push order over 20 cycles.
- Forwarding: buffer holds 0x200/0xAB. rd_addr_i=0x200 → rd_hit_o=1, rd_data_o=0xAB. Same cycle wr 0x200/0xCD → rd_data_o=0xCD. rd_addr_i=0x204 → rd_hit_o=0, rd_data_o=0.
- Head 0x300/0x1 is popping while wr 0x300/0x2 arrives → memory receives 0x1 now and 0x2 in a later beat, count_o ends at 1.
- Assert rst_i with 5 entries while mem_valid_o=1 → next cycle all outputs hold their reset values.
